// File: rtl/sort_stream_checker_pkg.sv
// Shared definitions for the sort stream checker and its sorter neighbour.
//   - default element width and sorter capacity
//   - sort mode codes used on the sorter's mode input
//   - checker FSM state encoding
//   - min_cnt(): number of elements the sorter returns for a batch
package sort_stream_checker_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N     = 22;

  // Sorter mode codes
  localparam logic [1:0] MODE_IDLE       = 2'd0;
  localparam logic [1:0] MODE_DESCENDING = 2'd1;
  localparam logic [1:0] MODE_ASCENDING  = 2'd2;
  localparam logic [1:0] MODE_FLUSH      = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} chk_state_t;

  // The sorter keeps at most cap elements, so a batch of cnt inputs
  // drains min(cnt, cap) outputs.
  function automatic int unsigned min_cnt(input int unsigned cnt, input int unsigned cap);
    return (cnt < cap) ? cnt : cap;
  endfunction

endpackage

// File: rtl/sort_stream_checker_if.sv
// Tap of the sorter's input and output streams.
//   in_data/in_valid   element entering the sorter
//   flush              end of batch, sorter starts draining
//   out_data/out_valid element leaving the sorter
// Handshake: both streams are observed taps with no backpressure; a beat
// exists exactly in a cycle where its valid is high, and data is only
// meaningful in that cycle. flush is a one-cycle strobe.
// master: the side that produces the streams; slave: the checker.
interface sort_stream_checker_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             flush;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;

  modport master (output in_data, in_valid, flush, out_data, out_valid);
  modport slave  (input  in_data, in_valid, flush, out_data, out_valid);
endinterface

// File: rtl/sort_stream_checker_stream_accum.sv
// Stream accumulator: saturating beat count, wrapping sum and XOR of data.
//   clk, rst_n   clock, async active-low reset
//   clr          restart accumulation (applied before en, so clr&en
//                leaves exactly the current beat accumulated)
//   en           accumulate data this cycle
//   data         beat value
//   count        registered beat count
//   count_nxt    value count takes at the next edge
//   sum_nxt      value the sum register takes at the next edge
//   xr_nxt       value the XOR register takes at the next edge
module stream_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6,
  parameter int SUM_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt,
  output logic [SUM_W-1:0] sum_nxt,
  output logic [WIDTH-1:0] xr_nxt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SUM_W-1:0] sum_q;
  logic [WIDTH-1:0] xr_q;

  always_comb begin
    count_nxt = clr ? '0 : count;
    sum_nxt   = clr ? '0 : sum_q;
    xr_nxt    = clr ? '0 : xr_q;
    if (en) begin
      if (count_nxt != CNT_MAX) count_nxt = count_nxt + CNT_W'(1);
      sum_nxt = sum_nxt + SUM_W'(data);
      xr_nxt  = xr_nxt ^ data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sum_q <= '0;
      xr_q  <= '0;
    end else begin
      count <= count_nxt;
      sum_q <= sum_nxt;
      xr_q  <= xr_nxt;
    end
  end
endmodule

// File: rtl/sort_stream_checker.sv
// Receive-side checker for the streaming top-N sorter. Watches a batch go
// in and come out, and checks output ordering, beat count and content
// (sum + XOR) against the input side.
//   clk, rst_n   clock, async active-low reset
//   strm         tapped input/output streams and flush (slave modport)
//   clear        synchronous return to IDLE, clears flags and counters
//   done         batch verdict available
//   pass         done and no error flag set
//   err_order    sticky: output beat broke the required ordering
//   err_count    sticky: too few / too many beats, or output before flush
//   err_sum      sticky: sum/XOR mismatch (only when no input was dropped)
//   err_tmo      sticky: drain did not complete within TIMEOUT cycles
//   out_count    output beats accepted in the current batch
//   dbg_state    current FSM state
module sort_stream_checker
  import sort_stream_checker_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int N          = DEF_N,
  parameter int DESCENDING = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sort_stream_checker_if.slave   strm,
  input  logic                   clear,
  output logic                   done,
  output logic                   pass,
  output logic                   err_order,
  output logic                   err_count,
  output logic                   err_sum,
  output logic                   err_tmo,
  output logic [$clog2(N+1)-1:0] out_count,
  output chk_state_t             dbg_state
);
  localparam int CW  = $clog2(N+1);
  localparam int ICW = CW + 1;        // input count can exceed N, saturates
  localparam int SW  = WIDTH + CW;
  localparam int TW  = $clog2(TIMEOUT+1);
  localparam logic [1:0] SORT_MODE = (DESCENDING != 0) ? MODE_DESCENDING : MODE_ASCENDING;

  chk_state_t state_q, state_d;

  logic [CW-1:0]    exp_q, exp_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic e_order_d, e_count_d, e_sum_d, e_tmo_d;

  logic in_clr, in_en, out_clr, out_en;
  logic [ICW-1:0]   in_cnt, in_cnt_nxt;
  logic [SW-1:0]    in_sum_nxt, out_sum_nxt;
  logic [WIDTH-1:0] in_xor_nxt, out_xor_nxt;
  logic [CW-1:0]    out_cnt, out_cnt_nxt;

  logic ovf, drain_hit, drain_tmo, order_bad;

  // Accumulator control depends only on registered state and inputs.
  // A new batch (in_valid in DONE) clears and counts its first beat at once.
  assign in_clr  = clear || (state_q == S_DONE && strm.in_valid);
  assign out_clr = in_clr;
  assign in_en   = !clear && strm.in_valid && (state_q != S_DRAIN);
  assign out_en  = !clear && strm.out_valid && (state_q == S_DRAIN);

  stream_accum #(.WIDTH(WIDTH), .CNT_W(ICW), .SUM_W(SW)) u_in_acc (
    .clk(clk), .rst_n(rst_n), .clr(in_clr), .en(in_en), .data(strm.in_data),
    .count(in_cnt), .count_nxt(in_cnt_nxt), .sum_nxt(in_sum_nxt), .xr_nxt(in_xor_nxt)
  );

  stream_accum #(.WIDTH(WIDTH), .CNT_W(CW), .SUM_W(SW)) u_out_acc (
    .clk(clk), .rst_n(rst_n), .clr(out_clr), .en(out_en), .data(strm.out_data),
    .count(out_cnt), .count_nxt(out_cnt_nxt), .sum_nxt(out_sum_nxt), .xr_nxt(out_xor_nxt)
  );

  // More inputs than capacity: the sorter dropped some, content check is void.
  assign ovf       = in_cnt > ICW'(N);
  assign drain_hit = strm.out_valid && (out_cnt_nxt == exp_q);
  assign drain_tmo = (tmo_q == TW'(TIMEOUT-1));
  assign order_bad = (SORT_MODE == MODE_DESCENDING) ? (strm.out_data > prev_q)
                                                    : (strm.out_data < prev_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (strm.in_valid) state_d = S_LOAD;
                 else if (strm.flush) state_d = S_DONE;
        S_LOAD:  if (strm.flush) state_d = S_DRAIN;
        S_DRAIN: if (drain_hit || drain_tmo) state_d = S_DONE;
        S_DONE:  if (strm.in_valid) state_d = S_LOAD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    exp_d     = exp_q;
    prev_d    = prev_q;
    tmo_d     = tmo_q;
    e_order_d = err_order;
    e_count_d = err_count;
    e_sum_d   = err_sum;
    e_tmo_d   = err_tmo;
    if (clear || (state_q == S_DONE && strm.in_valid)) begin
      exp_d     = '0;
      prev_d    = '0;
      tmo_d     = '0;
      e_order_d = 1'b0;
      e_count_d = 1'b0;
      e_sum_d   = 1'b0;
      e_tmo_d   = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (strm.out_valid) e_count_d = 1'b1;
          if (strm.flush) begin
            // in_cnt_nxt includes a beat arriving together with flush
            exp_d = CW'(min_cnt(32'(in_cnt_nxt), N));
            tmo_d = '0;
          end
        end
        S_DRAIN: begin
          tmo_d = tmo_q + TW'(1);
          if (strm.in_valid) e_count_d = 1'b1;
          if (strm.out_valid) begin
            prev_d = strm.out_data;
            if (out_cnt != '0 && order_bad) e_order_d = 1'b1;
          end
          if (drain_hit || drain_tmo) begin
            // The input side is frozen in DRAIN, so its _nxt equals its register.
            if (!ovf && (in_sum_nxt != out_sum_nxt || in_xor_nxt != out_xor_nxt))
              e_sum_d = 1'b1;
            // A completing beat in the timeout cycle wins; otherwise the batch
            // ended short, which is also a count error.
            if (!drain_hit) begin
              e_tmo_d   = 1'b1;
              e_count_d = 1'b1;
            end
          end
        end
        S_DONE: if (strm.out_valid) e_count_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= '0;
      prev_q    <= '0;
      tmo_q     <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_order <= 1'b0;
      err_count <= 1'b0;
      err_sum   <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      exp_q     <= exp_d;
      prev_q    <= prev_d;
      tmo_q     <= tmo_d;
      done      <= (state_d == S_DONE);
      pass      <= (state_d == S_DONE) && !(e_order_d || e_count_d || e_sum_d || e_tmo_d);
      err_order <= e_order_d;
      err_count <= e_count_d;
      err_sum   <= e_sum_d;
      err_tmo   <= e_tmo_d;
    end
  end

  assign out_count = out_cnt;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sort_stream_checker.sv
module tb_sort_stream_checker;
  import sort_stream_checker_pkg::*;

  localparam int W   = 8;
  localparam int NN  = 22;
  localparam int CW  = $clog2(NN+1);
  localparam int SUM_MASK = (1 << (W + CW)) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic done, pass, err_order, err_count, err_sum, err_tmo;
  logic [CW-1:0] out_count;
  chk_state_t dbg_state;

  sort_stream_checker_if #(.WIDTH(W)) bus ();

  sort_stream_checker #(.WIDTH(W), .N(NN), .DESCENDING(1), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .strm(bus), .clear(clear),
    .done(done), .pass(pass), .err_order(err_order), .err_count(err_count),
    .err_sum(err_sum), .err_tmo(err_tmo), .out_count(out_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_verdict(input string tag, input bit p, input bit o, input bit c,
                             input bit s, input bit t, input int cnt);
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".pass"}, 32'(pass), 32'(p));
    chk({tag, ".err_order"}, 32'(err_order), 32'(o));
    chk({tag, ".err_count"}, 32'(err_count), 32'(c));
    chk({tag, ".err_sum"}, 32'(err_sum), 32'(s));
    chk({tag, ".err_tmo"}, 32'(err_tmo), 32'(t));
    chk({tag, ".out_count"}, 32'(out_count), 32'(cnt));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic fl,
                       input logic ov, input logic [7:0] od, input logic cl);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.flush     = fl;
    bus.out_valid = ov;
    bus.out_data  = od;
    clear         = cl;
    tick();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_valid = 1'b0;
    clear         = 1'b0;
  endtask

  // Bounded wait for the verdict; the caller's done check reports expiry.
  task automatic wait_done();
    for (int k = 0; k < 200 && done !== 1'b1; k++) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string              name;
    int                 n_in;
    logic [31:0][7:0]   in_d;
    int                 n_out;
    logic [31:0][7:0]   out_d;
    bit                 e_pass, e_order, e_count, e_sum, e_tmo;
    int                 e_cnt;
    int                 e_lat;   // cycles from flush edge to done
  } vec_t;

  vec_t tbl[6];

  function automatic vec_t mk(input string nm, input int ni, input logic [255:0] id,
                              input int no, input logic [255:0] od,
                              input bit p, input bit o, input bit c, input bit s, input bit t,
                              input int cnt, input int lat);
    vec_t v;
    v.name = nm; v.n_in = ni; v.in_d = id; v.n_out = no; v.out_d = od;
    v.e_pass = p; v.e_order = o; v.e_count = c; v.e_sum = s; v.e_tmo = t;
    v.e_cnt = cnt; v.e_lat = lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int cf;
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < v.n_in; i++) drive(1, v.in_d[i], 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    cf = cyc;
    for (int i = 0; i < v.n_out; i++) drive(0, 0, 0, 1, v.out_d[i], 0);
    wait_done();
    chk_verdict(v.name, v.e_pass, v.e_order, v.e_count, v.e_sum, v.e_tmo, v.e_cnt);
    chk({v.name, ".latency"}, 32'(cyc - cf), 32'(v.e_lat));
  endtask

  // ---------------- randomized batches vs batch-level model ----------------
  task automatic run_random(input int idx);
    logic [7:0] ins[$];
    logic [7:0] srt[$];
    logic [7:0] outs[$];
    logic [7:0] tmp;
    int n_in, exp_n, mode, s_in, s_out, x_in, x_out;
    bit joint, e_o, e_c, e_s, e_t;
    string tag;
    tag = $sformatf("rand%0d", idx);
    n_in = $urandom_range(1, 30);
    for (int i = 0; i < n_in; i++) ins.push_back(8'($urandom_range(0, 255)));
    srt = ins;
    srt.rsort();
    exp_n = (n_in < NN) ? n_in : NN;
    for (int i = 0; i < exp_n; i++) outs.push_back(srt[i]);
    mode = $urandom_range(0, 4);
    if (mode == 1 && exp_n >= 2) begin
      int j;
      j = $urandom_range(0, exp_n - 2);
      tmp = outs[j]; outs[j] = outs[j+1]; outs[j+1] = tmp;
    end
    if (mode == 2) begin
      int j;
      j = $urandom_range(0, exp_n - 1);
      outs[j] = outs[j] ^ 8'($urandom_range(1, 255));
    end
    if (mode == 3) void'(outs.pop_back());

    drive(0, 0, 0, 0, 0, 1);
    joint = (n_in > 1) && ($urandom_range(0, 1) == 1);
    for (int i = 0; i < n_in; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      drive(1, ins[i], joint && (i == n_in - 1), 0, 0, 0);
    end
    if (!joint) drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < outs.size(); i++) begin
      if ($urandom_range(0, 1) == 1) tick();
      drive(0, 0, 0, 1, outs[i], 0);
    end
    wait_done();

    // Verdict from the batch rules
    e_o = 1'b0;
    for (int i = 1; i < outs.size(); i++) if (outs[i] > outs[i-1]) e_o = 1'b1;
    e_t = (outs.size() < exp_n);
    e_c = e_t;
    s_in = 0; x_in = 0; s_out = 0; x_out = 0;
    foreach (ins[i]) begin s_in += ins[i]; x_in ^= ins[i]; end
    foreach (outs[i]) begin s_out += outs[i]; x_out ^= outs[i]; end
    e_s = (n_in <= NN) && (((s_in & SUM_MASK) != (s_out & SUM_MASK)) || (x_in != x_out));
    if (mode == 4) begin
      drive(0, 0, 0, 1, 8'($urandom_range(0, 255)), 0);
      e_c = 1'b1;
    end
    chk_verdict(tag, !(e_o | e_c | e_s | e_t), e_o, e_c, e_s, e_t, outs.size());
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    bus.in_valid = 0; bus.in_data = 0; bus.flush = 0; bus.out_valid = 0; bus.out_data = 0;

    tbl[0] = mk("sorted", 5, 256'({8'd4, 8'd9, 8'd1, 8'd9, 8'd3}),
                5, 256'({8'd1, 8'd3, 8'd4, 8'd9, 8'd9}), 1, 0, 0, 0, 0, 5, 5);
    tbl[1] = mk("misorder", 5, 256'({8'd4, 8'd9, 8'd1, 8'd9, 8'd3}),
                5, 256'({8'd1, 8'd3, 8'd9, 8'd4, 8'd9}), 0, 1, 0, 0, 0, 5, 5);
    tbl[2] = mk("badvalue", 5, 256'({8'd4, 8'd9, 8'd1, 8'd9, 8'd3}),
                5, 256'({8'd2, 8'd3, 8'd4, 8'd9, 8'd9}), 0, 0, 0, 1, 0, 5, 5);
    tbl[3] = mk("overflow", 30, '0, 22, '0, 1, 0, 0, 0, 0, 22, 22);
    tbl[4] = mk("timeout", 30, '0, 21, '0, 0, 0, 1, 0, 1, 21, 64);
    tbl[5] = mk("pair7", 2, 256'({8'd7, 8'd7}), 2, 256'({8'd7, 8'd7}), 1, 0, 0, 0, 0, 2, 2);
    for (int i = 0; i < 30; i++) begin
      tbl[3].in_d[i] = 8'(i + 1);
      tbl[4].in_d[i] = 8'(i + 1);
    end
    for (int i = 0; i < 22; i++) begin
      tbl[3].out_d[i] = 8'(30 - i);
      tbl[4].out_d[i] = 8'(30 - i);
    end

    // Reset state
    #12;
    chk("reset.done", 32'(done), 0);
    chk("reset.pass", 32'(pass), 0);
    chk("reset.errs", 32'({err_order, err_count, err_sum, err_tmo}), 0);
    chk("reset.out_count", 32'(out_count), 0);
    chk("reset.state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Done latency: not done after the 4th beat, done right after the 5th
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(1, tbl[0].in_d[i], 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, tbl[0].out_d[i], 0);
    chk("lat.done_before_last", 32'(done), 0);
    drive(0, 0, 0, 1, tbl[0].out_d[4], 0);
    chk("lat.done_after_last", 32'(done), 1);
    chk("lat.pass", 32'(pass), 1);

    // Extra beat in DONE
    drive(0, 0, 0, 1, 8'd8, 0);
    chk_verdict("extra_beat", 0, 0, 1, 0, 0, 5);

    // New batch from DONE with a simultaneous output beat: beat dropped silently
    drive(1, 8'd5, 0, 1, 8'd3, 0);
    chk("newbatch.done", 32'(done), 0);
    chk("newbatch.err_count", 32'(err_count), 0);
    chk("newbatch.state", 32'(dbg_state), 32'(S_LOAD));
    chk("newbatch.out_count", 32'(out_count), 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 8'd5, 0);
    chk_verdict("newbatch", 1, 0, 0, 0, 0, 1);

    // Flush and input together in LOAD: that input is counted
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 8'd2, 0, 0, 0, 0);
    drive(1, 8'd6, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 8'd6, 0);
    chk("joint.done_after_1", 32'(done), 0);
    drive(0, 0, 0, 1, 8'd2, 0);
    chk_verdict("joint", 1, 0, 0, 0, 0, 2);

    // Output before flush
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 8'd4, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 8'd4, 0);
    chk("early_out.err_count", 32'(err_count), 1);
    chk("early_out.done", 32'(done), 0);

    // Async reset in the middle of DRAIN
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 8'd3, 0, 0, 0, 0);
    drive(1, 8'd9, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 8'd9, 0);
    chk("drain.out_count", 32'(out_count), 1);
    chk("drain.state", 32'(dbg_state), 32'(S_DRAIN));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst.out_count", 32'(out_count), 0);
    chk("async_rst.state", 32'(dbg_state), 32'(S_IDLE));
    chk("async_rst.flags", 32'({done, pass, err_order, err_count, err_sum, err_tmo}), 0);
    #1;
    rst_n = 1'b1;
    v = tbl[5];
    v.name = "after_reset";
    run_vec(v);

    // Flush in IDLE with no inputs
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 0);
    chk_verdict("empty", 1, 0, 0, 0, 0, 0);

    // Clear together with an output beat
    drive(0, 0, 0, 1, 8'd1, 1);
    chk("clear.done", 32'(done), 0);
    chk("clear.pass", 32'(pass), 0);
    chk("clear.errs", 32'({err_order, err_count, err_sum, err_tmo}), 0);
    chk("clear.state", 32'(dbg_state), 32'(S_IDLE));

    for (int i = 0; i < 40; i++) run_random(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
